// File: rtl/stream_mux_rr.sv
// N-input stream multiplexer with static, fixed-priority and round-robin
// arbitration feeding a single registered output stage.
module stream_mux_rr #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*W-1:0]         in_data,
  input  logic [N-1:0]           in_valid,
  output logic [N-1:0]           in_ready,
  input  logic [1:0]             mode,
  input  logic [$clog2(N)-1:0]   sel,
  output logic [W-1:0]           out_data,
  output logic [$clog2(N)-1:0]   out_chan,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned SW = $clog2(N);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_PRIO   = 2'b01,
    MODE_RR     = 2'b10,
    MODE_ALIAS  = 2'b11
  } mode_e;

  mode_e          mode_s;
  logic [SW-1:0]  ptr;
  logic [SW-1:0]  ptr_next;
  logic [SW-1:0]  g;
  logic           grant;
  logic           load_en;
  logic [W-1:0]   g_data;

  assign mode_s  = mode_e'(mode);
  assign load_en = !out_valid || out_ready;

  // Reset gates the grant so in_ready stays low while rst_n is asserted,
  // even though the output register then reads as empty.
  always_comb begin
    grant = 1'b0;
    g     = '0;
    if (rst_n && load_en) begin
      case (mode_s)
        MODE_PRIO: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (!grant && in_valid[i]) begin
              grant = 1'b1;
              g     = SW'(i);
            end
          end
        end
        MODE_RR: begin
          // Outer loop pins the pointer value so every index stays constant.
          for (int unsigned j = 0; j < N; j++) begin
            if (ptr == SW'(j)) begin
              for (int unsigned i = 0; i < N; i++) begin
                if (!grant && in_valid[(i + j) % N]) begin
                  grant = 1'b1;
                  g     = SW'((i + j) % N);
                end
              end
            end
          end
        end
        default: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (sel == SW'(i) && in_valid[i]) begin
              grant = 1'b1;
              g     = SW'(i);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    in_ready = '0;
    g_data   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (g == SW'(i)) begin
        in_ready[i] = grant;
        g_data      = in_data[i*W +: W];
      end
    end
  end

  assign ptr_next = (g == SW'(N - 1)) ? '0 : g + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_chan  <= g;
      if (mode_s == MODE_RR) begin
        ptr <= ptr_next;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (1..64).
REQ-003 SHALL derive localparam SW = clog2(N), the width of the channel index.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_data  input  N*W  channel c occupies bits [c*W +: W].
REQ-007 SHALL have port in_valid  input  N  per-channel data valid.
REQ-008 SHALL have port in_ready  output  N  per-channel accept strobe, combinational.
REQ-009 SHALL have port mode  input  2  00 static select, 01 fixed priority, 10 round-robin, 11 treated as 00.
REQ-010 SHALL have port sel  input  SW  channel index used in static mode.
REQ-011 SHALL have port out_data  output  W  registered selected data.
REQ-012 SHALL have port out_chan  output  SW  registered index of the channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  output register holds a beat.
REQ-014 SHALL have port out_ready  input  1  downstream accepts a beat.

Function
REQ-015 SHALL hold a single output register stage; load_en = !out_valid | out_ready.
REQ-016 SHALL pick at most one channel g per cycle, and only when load_en=1.
- static: g = sel if in_valid[sel] and sel < N; sel >= N never grants.
- fixed priority: g = lowest index with in_valid set.
- round-robin: g = first index with in_valid set, searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
REQ-017 SHALL drive in_ready[g]=1 only when a grant occurs, with all other in_ready bits 0; with no grant, in_ready is all 0.
REQ-018 SHALL make in_ready independent of in_data; it may depend on in_valid, mode, sel, ptr, out_valid and out_ready.
REQ-019 SHALL, on grant, load out_data <= in_data[g], out_chan <= g and out_valid <= 1 at the next edge.
REQ-020 SHALL, when out_valid & out_ready and there is no grant, clear out_valid at the next edge; out_data and out_chan hold their last values.
REQ-021 SHALL hold out_data and out_chan stable while out_valid=1 and out_ready=0.
REQ-022 SHALL sustain one beat per cycle when out_ready is held at 1; latency from input accept to out_valid is 1 cycle.
REQ-023 SHALL keep a round-robin pointer ptr (SW bits, range 0..N-1).
- Updates only on a grant in round-robin mode: ptr <= (g+1) mod N, wrapping N-1 -> 0.
- Holds its value in other modes and across mode changes.
REQ-024 SHALL sample mode and sel combinationally each cycle; a change affects only the arbitration in that cycle and never disturbs the beat already held.
REQ-025 SHALL not starve any requester in round-robin mode: a channel held valid is granted within N grants.
REQ-026 SHALL ignore in_valid on channels that are not granted; the upstream source holds its data until it sees in_ready.
REQ-027 SHALL never drop or duplicate a beat: every beat accepted at the input appears exactly once at the output.

Reset
REQ-028 SHALL, while rst_n=0 (taking effect immediately, independent of clk), force out_valid=0, out_data=0, out_chan=0, ptr=0 and in_ready all 0.
REQ-029 SHALL discard a held beat when reset is asserted mid-transfer; the first grant after release follows normal rules with ptr=0.
REQ-030 SHALL make its first grant at the first rising edge after rst_n deasserts.

Verification
REQ-031 Round-robin, N=4, all in_valid=1111, out_ready=1, data of channel c = 8'hA0+c -> out_chan sequence 0,1,2,3,0 on consecutive cycles, out_data A0,A1,A2,A3,A0.
REQ-032 Fixed priority, in_valid=1010, out_ready=1 -> out_chan is always 1; channel 3 is never granted.
REQ-033 Static, sel=2, in_valid=1111 -> out_chan=2 and out_data=in_data[2] every beat; with sel=2 and in_valid=1011, in_ready=0000 and out_valid drops after the drain.
REQ-034 Backpressure: beat 8'h55 held in the output register, out_ready=0 for 5 cycles -> out_data=55 stable, in_ready=0000, ptr unchanged; on the first out_ready=1 cycle the next beat loads.
REQ-035 Round-robin, ptr=3, only in_valid[3] and in_valid[0] set -> grant 3, then grant 0, then ptr=1.
REQ-036 rst_n pulled low asynchronously mid-cycle while out_valid=1 -> out_valid=0, out_data=0, out_chan=0 immediately; after release with in_valid=1111, the first grant is channel 0.
